// File: rtl/mac_pkg.sv
// Shared definitions for the MAC sequencer: default widths and the FSM state type.
package mac_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_LEN_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ACCUM   = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_RESOLVE = 3'd3,
    ST_DONE    = 3'd4
  } mac_seq_state_e;

endpackage

// File: rtl/mac_csa.sv
// Bitwise 3:2 carry-save compressor. The carry is returned unshifted; the
// caller aligns it to the next bit position.
module mac_csa #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_c,
  output logic [WIDTH-1:0] o_sum,
  output logic [WIDTH-1:0] o_carry
);

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      assign o_sum[gi]   = i_a[gi] ^ i_b[gi] ^ i_c[gi];
      assign o_carry[gi] = (i_a[gi] & i_b[gi]) | (i_a[gi] & i_c[gi]) | (i_b[gi] & i_c[gi]);
    end
  endgenerate

endmodule

// File: rtl/mac_seq_ctrl.sv
// Dot-product sequencer: registered multiply, carry-save accumulate, one
// final carry-propagate add, and a valid/ready result port.
module mac_seq_ctrl
  import mac_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int IN_WIDTH  = DEF_IN_WIDTH,
  parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_start,
  input  logic [LEN_WIDTH-1:0] i_len,
  output logic                 o_busy,
  input  logic                 i_op_valid,
  output logic                 o_op_ready,
  input  logic [IN_WIDTH-1:0]  i_op_a,
  input  logic [IN_WIDTH-1:0]  i_op_b,
  output logic                 o_res_valid,
  input  logic                 i_res_ready,
  output logic [WIDTH-1:0]     o_res
);

  localparam logic [LEN_WIDTH-1:0] LEN_ONE = LEN_WIDTH'(1);

  mac_seq_state_e        r_state;
  logic [WIDTH-1:0]      r_p;
  logic                  r_p_vld;
  logic [WIDTH-1:0]      r_acc_s;
  logic [WIDTH-1:0]      r_acc_c;
  logic [WIDTH-1:0]      r_res;
  logic [LEN_WIDTH-1:0]  r_cnt;
  logic [LEN_WIDTH-1:0]  r_len;

  logic [2*IN_WIDTH-1:0] w_mul;
  logic [WIDTH-1:0]      w_sum;
  logic [WIDTH-1:0]      w_carry;
  logic                  w_accept;
  logic                  w_last;

  assign w_mul    = i_op_a * i_op_b;
  assign w_accept = i_op_valid && (r_state == ST_ACCUM);
  assign w_last   = (r_cnt == (r_len - LEN_ONE));

  mac_csa #(.WIDTH(WIDTH)) u_csa (
    .i_a     (r_acc_s),
    .i_b     (r_acc_c),
    .i_c     (r_p),
    .o_sum   (w_sum),
    .o_carry (w_carry)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_p     <= '0;
      r_p_vld <= 1'b0;
      r_acc_s <= '0;
      r_acc_c <= '0;
      r_res   <= '0;
      r_cnt   <= '0;
      r_len   <= '0;
    end else begin
      // The CSA stage runs off p_vld alone, so the last product folds in during DRAIN.
      if (r_p_vld) begin
        r_acc_s <= w_sum;
        r_acc_c <= {w_carry[WIDTH-2:0], 1'b0};
      end
      r_p_vld <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_acc_s <= '0;
            r_acc_c <= '0;
            r_cnt   <= '0;
            r_len   <= i_len;
            r_state <= (i_len != '0) ? ST_ACCUM : ST_RESOLVE;
          end
        end
        ST_ACCUM: begin
          if (w_accept) begin
            r_p     <= WIDTH'(w_mul);
            r_p_vld <= 1'b1;
            r_cnt   <= r_cnt + LEN_ONE;
            if (w_last) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          r_state <= ST_RESOLVE;
        end
        ST_RESOLVE: begin
          r_res   <= r_acc_s + r_acc_c;
          r_state <= ST_DONE;
        end
        ST_DONE: begin
          if (i_res_ready) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy      = (r_state != ST_IDLE);
  assign o_op_ready  = (r_state == ST_ACCUM);
  assign o_res_valid = (r_state == ST_DONE);
  assign o_res       = r_res;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Directed and randomized jobs through mac_seq_ctrl, checked against a plain
// modular dot-product model with cycle-exact result timing.
module tb_mac_seq_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_start = 1'b0;
  logic [7:0]  i_len = '0;
  logic        o_busy;
  logic        i_op_valid = 1'b0;
  logic        o_op_ready;
  logic [15:0] i_op_a = '0;
  logic [15:0] i_op_b = '0;
  logic        o_res_valid;
  logic        i_res_ready = 1'b0;
  logic [31:0] o_res;

  int errors = 0;
  int checks = 0;

  logic [15:0] va [0:15];
  logic [15:0] vb [0:15];

  mac_seq_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start     (i_start),
    .i_len       (i_len),
    .o_busy      (o_busy),
    .i_op_valid  (i_op_valid),
    .o_op_ready  (o_op_ready),
    .i_op_a      (i_op_a),
    .i_op_b      (i_op_b),
    .o_res_valid (o_res_valid),
    .i_res_ready (i_res_ready),
    .o_res       (o_res)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference: modular sum of products of the first n pairs.
  function automatic logic [31:0] model(input int n);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < n; i++) acc = acc + (32'(va[i]) * 32'(vb[i]));
    return acc;
  endfunction

  // One complete job. max_gap: random idle cycles between operands;
  // hold: cycles with i_res_ready low; poke: pulse i_start while busy.
  task automatic do_job(input string name, input int n, input int max_gap,
                        input int hold, input bit poke);
    logic [31:0] exp_res;
    int gap;
    exp_res = model(n);
    i_start = 1'b1;
    i_len   = 8'(n);
    tick();
    i_start = 1'b0;
    chk({name, ".busy_after_start"}, o_busy, 1);
    chk({name, ".ready_after_start"}, o_op_ready, (n > 0));
    for (int i = 0; i < n; i++) begin
      gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
      for (int g = 0; g < gap; g++) begin
        i_op_valid = 1'b0;
        i_start    = poke ? 1'($urandom_range(0, 1)) : 1'b0;
        i_len      = 8'($urandom_range(0, 255));
        tick();
      end
      i_start    = 1'b0;
      i_op_valid = 1'b1;
      i_op_a     = va[i];
      i_op_b     = vb[i];
      chk({name, ".ready_before_accept"}, o_op_ready, 1);
      tick();
    end
    i_op_valid = 1'b0;
    if (n > 0) begin
      chk({name, ".ready_low_after_last"}, o_op_ready, 0);
      chk({name, ".valid_k1"}, o_res_valid, 0);
      tick();
    end
    chk({name, ".valid_before_resolve"}, o_res_valid, 0);
    chk({name, ".ready_never_late"}, o_op_ready, 0);
    tick();
    chk({name, ".valid"}, o_res_valid, 1);
    chk({name, ".res"}, o_res, exp_res);
    i_res_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      i_start = poke;
      i_len   = 8'd3;
      tick();
      chk({name, ".valid_held"}, o_res_valid, 1);
      chk({name, ".res_held"}, o_res, exp_res);
    end
    i_res_ready = 1'b1;
    tick();
    i_res_ready = 1'b0;
    i_start     = 1'b0;
    chk({name, ".idle_after_hs"}, o_busy, 0);
    chk({name, ".valid_after_hs"}, o_res_valid, 0);
    chk({name, ".res_kept"}, o_res, exp_res);
    $display("job %s len=%0d result=%0h expected=%0h", name, n, o_res, exp_res);
  endtask

  initial begin
    #2;
    chk("reset.busy", o_busy, 0);
    chk("reset.ready", o_op_ready, 0);
    chk("reset.valid", o_res_valid, 0);
    chk("reset.res", o_res, 0);
    #10;
    i_rst = 1'b0;
    tick();

    va[0] = 16'd2; vb[0] = 16'd3;
    va[1] = 16'd4; vb[1] = 16'd5;
    va[2] = 16'd6; vb[2] = 16'd7;
    do_job("basic", 3, 0, 0, 1'b0);
    chk("basic.const", o_res, 68);

    va[0] = 16'hFFFF; vb[0] = 16'hFFFF;
    va[1] = 16'hFFFF; vb[1] = 16'hFFFF;
    do_job("wrap", 2, 0, 0, 1'b0);
    chk("wrap.const", o_res, 32'hFFFC0002);

    do_job("zero", 0, 0, 1, 1'b0);
    chk("zero.const", o_res, 0);

    // Operand traffic while idle must not be accepted.
    for (int i = 0; i < 3; i++) begin
      i_op_valid = 1'b1;
      i_op_a = 16'($urandom);
      i_op_b = 16'($urandom);
      tick();
      chk("idle_op.busy", o_busy, 0);
      chk("idle_op.ready", o_op_ready, 0);
    end
    i_op_valid = 1'b0;

    for (int i = 0; i < 4; i++) begin
      va[i] = 16'(i + 1);
      vb[i] = 16'(i + 1);
    end
    do_job("stall", 4, 3, 5, 1'b1);
    chk("stall.const", o_res, 30);

    for (int j = 0; j < 6; j++) begin
      int n;
      n = int'($urandom_range(1, 12));
      for (int i = 0; i < n; i++) begin
        va[i] = 16'($urandom);
        vb[i] = 16'($urandom);
      end
      do_job($sformatf("rand%0d", j), n, j % 4, j % 3, 1'(j % 2));
    end

    // Asynchronous reset after 2 of 5 terms.
    i_start = 1'b1;
    i_len   = 8'd5;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      i_op_valid = 1'b1;
      i_op_a = 16'($urandom);
      i_op_b = 16'($urandom);
      tick();
    end
    #2;
    i_rst = 1'b1;
    #1;
    chk("rst.busy", o_busy, 0);
    chk("rst.ready", o_op_ready, 0);
    chk("rst.valid", o_res_valid, 0);
    chk("rst.res", o_res, 0);
    #1;
    i_rst = 1'b0;
    i_op_valid = 1'b0;
    tick();
    chk("rst.idle", o_busy, 0);
    $display("reset mid-job applied, busy=%0d res=%0h", o_busy, o_res);

    va[0] = 16'd7; vb[0] = 16'd9;
    do_job("post_rst", 1, 0, 0, 1'b0);
    chk("post_rst.const", o_res, 63);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
